uart_parity_engine: RTL
=======================

# uart_parity_engine

Parametrised parity unit for the UART datapath, successor to the fixed even/odd 8-bit parity calculator. It generates the TX parity bit from a captured parallel word and checks RX parity by accumulating data bits serially as the receiver shifts them in. It supports even, odd, mark and space parity, a per-frame bit-count guard, and a saturating parity-error counter. It sits between the UART TX/RX FSMs and the status register block.

## Interface
- WIDTH, 8, data bits per frame; legal range 5..9.
- CNT_W, 8, width of the parity-error counter.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- par_en  in  1  parity enabled; 0 means no parity in the frame.
- par_mode  in  2  00 even, 01 odd, 10 mark (always 1), 11 space (always 0).
- tx_load  in  1  capture tx_data and par_mode for the TX parity computation.
- tx_data  in  WIDTH  parallel TX word.
- tx_parity  out  1  parity bit for the TX serializer.
- rx_start  in  1  start-of-frame strobe; clears the accumulator and samples par_mode and par_en.
- rx_bit_valid  in  1  rx_bit is a data bit, LSB first.
- rx_bit  in  1  received serial bit.
- rx_chk  in  1  rx_bit is the received parity bit; ends the frame.
- rx_done  out  1  one-cycle pulse; frame check completed.
- rx_par_err  out  1  one-cycle pulse coincident with rx_done; parity mismatch.
- rx_seq_err  out  1  one-cycle pulse; bit-count violation.
- err_clr  in  1  synchronous clear of err_count.
- err_count  out  CNT_W  saturating count of rx_par_err pulses.

## Operation
- **TX path**
  - On tx_load, register tx_data and par_mode into tx_word and tx_mode.
  - tx_parity is a registered function of tx_word and tx_mode: even gives XOR-reduce, odd gives XNOR-reduce, mark gives 1, space gives 0.
  - If the sampled par_en is 0, tx_parity is 0.
  - Between loads, tx_parity holds its value. Changes on par_mode do not affect it until the next tx_load.
- **RX FSM states**
  - IDLE: wait for rx_start.
  - ACCUM: XOR each valid rx_bit into acc and increment bit_cnt.
  - CHECK: single cycle; generate outputs, then return to IDLE.
- **RX transitions**
  - rx_start in any state goes to ACCUM with acc=0, bit_cnt=0, and mode/en sampled. This includes a restart mid-frame; the partial frame is discarded with no pulse.
  - In ACCUM, rx_chk with bit_cnt==WIDTH goes to CHECK.
    - Expected parity is acc for even, ~acc for odd, 1 for mark, 0 for space.
    - rx_par_err = par_en & (rx_bit != expected).
  - In ACCUM, rx_chk with bit_cnt<WIDTH: rx_seq_err and rx_done pulse, rx_par_err stays 0, go to IDLE.
  - rx_bit_valid when bit_cnt==WIDTH: rx_seq_err pulse, bit ignored, stay in ACCUM.
  - rx_bit_valid and rx_chk together: rx_chk is ignored and a rx_seq_err pulse is raised.
  - rx_bit_valid or rx_chk in IDLE: ignored, no pulse.
  - With par_en=0, the frame completes on rx_chk and rx_bit is ignored; the RX FSM sequences rx_chk at the stop position.
- **Counter**
  - err_count increments on each rx_par_err and saturates at 2^CNT_W−1.
  - err_clr wins over a same-cycle increment.
- bit_cnt is $clog2(WIDTH+1) bits wide and never wraps; it saturates at WIDTH.

## Timing
- Reset values: tx_parity=0, rx_done=0, rx_par_err=0, rx_seq_err=0, err_count=0, FSM=IDLE, acc=0, bit_cnt=0, tx_word=0.
- tx_parity is valid 1 cycle after the tx_load edge.
- rx_done/rx_par_err are high in the cycle after the rx_chk edge (CHECK state) for exactly 1 cycle.
- rx_seq_err is high in the cycle after the offending strobe.
- err_count reflects the error 1 cycle after rx_par_err, i.e. 2 cycles after rx_chk.
- Back-to-back frames: rx_start is accepted in the CHECK cycle and takes priority; the current check outputs still pulse.
- Asserting rst mid-frame immediately clears all state and outputs; no pulse is generated.

## Structure
- Shared package uart_pkg:
  - PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE encodings.
  - RX parity FSM state enum.
  - Function par_expect(acc, mode) used by both paths.
- Sub-module uart_parity_rx holds the RX FSM, accumulator and bit counter. The top holds the TX register and the error counter.

## Test plan
- WIDTH=8, even, tx_load 8'hA5 → tx_parity=0 next cycle. Odd, 8'hA7 → 0. Mark → 1. par_en=0 → 0.
- WIDTH=8, odd: rx_start, bits of 8'h01, rx_chk rx_bit=0 → rx_done=1, rx_par_err=0. Repeat with rx_bit=1 → rx_par_err=1, err_count=1.
- rx_chk after 5 of 8 bits → rx_seq_err and rx_done, no rx_par_err. A 9th rx_bit_valid → rx_seq_err, frame then completes normally.
- rx_start after 4 bits, then a full 8-bit frame of 8'hFF, even, parity 0 → no error; first partial frame produces no pulse.
- CNT_W=2: 5 parity errors → err_count saturates at 3. err_clr with a same-cycle error → 0.
- rst low mid-ACCUM after 3 bits → all outputs 0. After release a full frame checks correctly. WIDTH=5 and WIDTH=9 regressions.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared parity encodings, RX FSM states and expected-parity helper
package uart_pkg;

  localparam logic [1:0] PAR_EVEN  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'b00,
    RX_ACCUM = 2'b01,
    RX_CHECK = 2'b10
  } rx_state_t;

  // acc is the XOR of all data bits; mark/space ignore it
  function automatic logic par_expect(input logic acc, input logic [1:0] mode);
    logic w_exp;
    case (mode)
      PAR_EVEN: w_exp = acc;
      PAR_ODD:  w_exp = ~acc;
      PAR_MARK: w_exp = 1'b1;
      default:  w_exp = 1'b0;
    endcase
    return w_exp;
  endfunction

endpackage

// File: rtl/uart_parity_rx.sv
// rtl/uart_parity_rx.sv - serial RX parity accumulator with bit-count guard
module uart_parity_rx
  import uart_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       par_en,
  input  logic [1:0] par_mode,
  input  logic       rx_start,
  input  logic       rx_bit_valid,
  input  logic       rx_bit,
  input  logic       rx_chk,
  output logic       rx_done,
  output logic       rx_par_err,
  output logic       rx_seq_err
);

  localparam int BCW = $clog2(WIDTH + 1);
  localparam logic [BCW-1:0] FULL = BCW'(WIDTH);

  rx_state_t      r_state;
  logic           r_acc;
  logic [BCW-1:0] r_bit_cnt;
  logic [1:0]     r_mode;
  logic           r_en;
  logic           r_done;
  logic           r_par_err;
  logic           r_seq_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= RX_IDLE;
      r_acc     <= 1'b0;
      r_bit_cnt <= '0;
      r_mode    <= PAR_EVEN;
      r_en      <= 1'b0;
      r_done    <= 1'b0;
      r_par_err <= 1'b0;
      r_seq_err <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_par_err <= 1'b0;
      r_seq_err <= 1'b0;
      // A start strobe always wins, silently discarding any partial frame
      if (rx_start) begin
        r_state   <= RX_ACCUM;
        r_acc     <= 1'b0;
        r_bit_cnt <= '0;
        r_mode    <= par_mode;
        r_en      <= par_en;
      end else begin
        case (r_state)
          RX_ACCUM: begin
            if (rx_bit_valid) begin
              if (r_bit_cnt != FULL) begin
                r_acc     <= r_acc ^ rx_bit;
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end else begin
                r_seq_err <= 1'b1;
              end
              if (rx_chk) r_seq_err <= 1'b1;
            end else if (rx_chk) begin
              r_done <= 1'b1;
              if (r_bit_cnt == FULL) begin
                r_state   <= RX_CHECK;
                r_par_err <= r_en & (rx_bit != par_expect(r_acc, r_mode));
              end else begin
                r_state   <= RX_IDLE;
                r_seq_err <= 1'b1;
              end
            end
          end
          RX_CHECK: r_state <= RX_IDLE;
          default:  r_state <= RX_IDLE;
        endcase
      end
    end
  end

  assign rx_done    = r_done;
  assign rx_par_err = r_par_err;
  assign rx_seq_err = r_seq_err;

endmodule

// File: rtl/uart_parity_engine.sv
// rtl/uart_parity_engine.sv - UART TX parity generator, RX parity checker and error counter
module uart_parity_engine
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             par_en,
  input  logic [1:0]       par_mode,
  input  logic             tx_load,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_parity,
  input  logic             rx_start,
  input  logic             rx_bit_valid,
  input  logic             rx_bit,
  input  logic             rx_chk,
  output logic             rx_done,
  output logic             rx_par_err,
  output logic             rx_seq_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] r_tx_word;
  logic [1:0]       r_tx_mode;
  logic             r_tx_en;
  logic [CNT_W-1:0] r_err_count;
  logic             w_par_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_word <= '0;
      r_tx_mode <= PAR_EVEN;
      r_tx_en   <= 1'b0;
    end else if (tx_load) begin
      r_tx_word <= tx_data;
      r_tx_mode <= par_mode;
      r_tx_en   <= par_en;
    end
  end

  // Depends only on registered state, so par_mode edits between loads are invisible
  assign tx_parity = r_tx_en & par_expect(^r_tx_word, r_tx_mode);

  uart_parity_rx #(.WIDTH(WIDTH)) u_rx (
    .clk          (clk),
    .rst          (rst),
    .par_en       (par_en),
    .par_mode     (par_mode),
    .rx_start     (rx_start),
    .rx_bit_valid (rx_bit_valid),
    .rx_bit       (rx_bit),
    .rx_chk       (rx_chk),
    .rx_done      (rx_done),
    .rx_par_err   (w_par_err),
    .rx_seq_err   (rx_seq_err)
  );

  assign rx_par_err = w_par_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_count <= '0;
    end else if (err_clr) begin
      r_err_count <= '0;
    end else if (w_par_err && (r_err_count != CNT_MAX)) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  assign err_count = r_err_count;

endmodule
